// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the 9-bit CPU program loader: opcodes, function codes,
// command kinds, encoder states and the instruction-word packing helpers.
package instr_encoder_pkg;

    localparam logic [4:0] OP_VALL       = 5'h00;
    localparam logic [4:0] OP_VALH       = 5'h01;
    localparam logic [4:0] OP_INCR       = 5'h12;
    localparam logic [4:0] OP_UNASSIGNED = 5'h18;
    localparam logic [4:0] OP_FUNC       = 5'h1F;
    localparam logic [3:0] FN_DNE        = 4'hF;

    typedef enum logic [1:0] {
        KIND_RAW  = 2'd0,
        KIND_LDI  = 2'd1,
        KIND_END  = 2'd2,
        KIND_RSVD = 2'd3
    } cmd_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WR_HI  = 2'd2,
        ST_DONE   = 2'd3
    } enc_state_e;

    function automatic logic [8:0] pack_word(input logic [4:0] op, input logic [3:0] arg);
        return {op, arg};
    endfunction

    // Opcodes a RAW command may not carry: unassigned, or immediates that must go via LDI.
    function automatic logic raw_op_illegal(input logic [4:0] op);
        return (op == OP_UNASSIGNED) || (op == OP_VALL) || (op == OP_VALH);
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Command handshake and instruction-memory write bus of the program loader.
interface instr_encoder_if #(parameter int ADDR_W = 8);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_kind;
    logic [4:0]        cmd_op;
    logic [3:0]        cmd_arg;
    logic [7:0]        cmd_imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [8:0]        mem_wdata;

    modport master (
        output cmd_valid, cmd_kind, cmd_op, cmd_arg, cmd_imm,
        input  cmd_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  cmd_valid, cmd_kind, cmd_op, cmd_arg, cmd_imm,
        output cmd_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/instr_encoder.sv
// Program-loader back end: packs encode commands into 9-bit words and writes them to memory.
// Optional build macro INSTR_ENC_CHECK_EN rejects RAW words with illegal opcodes.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    instr_encoder_if.slave    cmd,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic              err
);

    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

    enc_state_e        state_r, state_n;
    logic [ADDR_W-1:0] addr_r, addr_n;
    logic [ADDR_W-1:0] waddr_r, waddr_n;
    logic              we_r, we_n;
    logic [8:0]        wdata_r, wdata_n;
    logic              ovf_r, ovf_n;
    logic              err_r, err_n;
    logic [3:0]        imm_hi_r, imm_hi_n;
    logic              last_s;
    logic              raw_reject_s;
    cmd_kind_e         kind_s;

    assign kind_s = cmd_kind_e'(cmd.cmd_kind);
    assign last_s = (addr_r == ADDR_LAST);

`ifdef INSTR_ENC_CHECK_EN
    assign raw_reject_s = raw_op_illegal(cmd.cmd_op);
`else
    assign raw_reject_s = 1'b0;
`endif

    // Next-state, address counter and write-register logic.
    always_comb begin
        state_n  = state_r;
        addr_n   = addr_r;
        waddr_n  = waddr_r;
        we_n     = 1'b0;
        wdata_n  = wdata_r;
        ovf_n    = ovf_r;
        err_n    = 1'b0;
        imm_hi_n = imm_hi_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_n = ST_ACCEPT;
                    addr_n  = start_addr;
                    ovf_n   = 1'b0;
                end else begin
                    state_n = state_r;
                end
            end
            ST_ACCEPT: begin
                if (cmd.cmd_valid) begin
                    case (kind_s)
                        KIND_RAW: begin
                            if (raw_reject_s) begin
                                err_n = 1'b1;
                            end else begin
                                we_n    = 1'b1;
                                waddr_n = addr_r;
                                wdata_n = pack_word(cmd.cmd_op, cmd.cmd_arg);
                                if (last_s) begin
                                    ovf_n   = 1'b1;
                                    state_n = ST_DONE;
                                end else begin
                                    addr_n = addr_r + ADDR_ONE;
                                end
                            end
                        end
                        KIND_LDI: begin
                            we_n     = 1'b1;
                            waddr_n  = addr_r;
                            wdata_n  = pack_word(OP_VALL, cmd.cmd_imm[3:0]);
                            imm_hi_n = cmd.cmd_imm[7:4];
                            // No room for the high word: drop it and terminate.
                            if (last_s) begin
                                ovf_n   = 1'b1;
                                state_n = ST_DONE;
                            end else begin
                                addr_n  = addr_r + ADDR_ONE;
                                state_n = ST_WR_HI;
                            end
                        end
                        KIND_END: begin
                            we_n    = 1'b1;
                            waddr_n = addr_r;
                            wdata_n = pack_word(OP_FUNC, FN_DNE);
                            state_n = ST_DONE;
                            if (last_s) begin
                                addr_n = addr_r;
                            end else begin
                                addr_n = addr_r + ADDR_ONE;
                            end
                        end
                        default: begin
                            err_n = 1'b1;
                        end
                    endcase
                end else begin
                    state_n = ST_ACCEPT;
                end
            end
            ST_WR_HI: begin
                we_n    = 1'b1;
                waddr_n = addr_r;
                wdata_n = pack_word(OP_VALH, imm_hi_r);
                if (last_s) begin
                    ovf_n   = 1'b1;
                    state_n = ST_DONE;
                end else begin
                    addr_n  = addr_r + ADDR_ONE;
                    state_n = ST_ACCEPT;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            addr_r   <= {ADDR_W{1'b0}};
            waddr_r  <= {ADDR_W{1'b0}};
            we_r     <= 1'b0;
            wdata_r  <= 9'h000;
            ovf_r    <= 1'b0;
            err_r    <= 1'b0;
            imm_hi_r <= 4'h0;
        end else begin
            state_r  <= state_n;
            addr_r   <= addr_n;
            waddr_r  <= waddr_n;
            we_r     <= we_n;
            wdata_r  <= wdata_n;
            ovf_r    <= ovf_n;
            err_r    <= err_n;
            imm_hi_r <= imm_hi_n;
        end
    end

    assign cmd.cmd_ready = (state_r == ST_ACCEPT);
    assign cmd.mem_we    = we_r;
    assign cmd.mem_addr  = waddr_r;
    assign cmd.mem_wdata = wdata_r;
    assign busy          = (state_r == ST_ACCEPT) || (state_r == ST_WR_HI);
    assign done          = (state_r == ST_DONE);
    assign ovf           = ovf_r;
    assign err           = err_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: an 8-bit-address instance for the main flow and a
// 2-bit-address instance for the end-of-memory cases, sharing one stimulus driver.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       sel;
    logic       c_valid, c_start;
    logic [1:0] c_kind;
    logic [4:0] c_op;
    logic [3:0] c_arg;
    logic [7:0] c_imm;
    logic [7:0] c_start_addr;

    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(8)) ia ();
    instr_encoder_if #(.ADDR_W(2)) ib ();

    logic busy_a, done_a, ovf_a, err_a;
    logic busy_b, done_b, ovf_b, err_b;

    assign ia.cmd_valid = c_valid & ~sel;
    assign ia.cmd_kind  = c_kind;
    assign ia.cmd_op    = c_op;
    assign ia.cmd_arg   = c_arg;
    assign ia.cmd_imm   = c_imm;
    assign ib.cmd_valid = c_valid & sel;
    assign ib.cmd_kind  = c_kind;
    assign ib.cmd_op    = c_op;
    assign ib.cmd_arg   = c_arg;
    assign ib.cmd_imm   = c_imm;

    instr_encoder #(.ADDR_W(8)) dut_a (
        .clk(clk), .reset(reset), .start(c_start & ~sel), .start_addr(c_start_addr),
        .cmd(ia), .busy(busy_a), .done(done_a), .ovf(ovf_a), .err(err_a)
    );

    instr_encoder #(.ADDR_W(2)) dut_b (
        .clk(clk), .reset(reset), .start(c_start & sel), .start_addr(c_start_addr[1:0]),
        .cmd(ib), .busy(busy_b), .done(done_b), .ovf(ovf_b), .err(err_b)
    );

    wire       m_ready = sel ? ib.cmd_ready : ia.cmd_ready;
    wire       m_we    = sel ? ib.mem_we : ia.mem_we;
    wire [7:0] m_addr  = sel ? {6'b000000, ib.mem_addr} : ia.mem_addr;
    wire [8:0] m_wdata = sel ? ib.mem_wdata : ia.mem_wdata;
    wire       m_busy  = sel ? busy_b : busy_a;
    wire       m_done  = sel ? done_b : done_a;
    wire       m_ovf   = sel ? ovf_b : ovf_a;
    wire       m_err   = sel ? err_b : err_a;

    logic [16:0] wr_q[$];
    int          err_cnt = 0;

    // Memory-write and error-pulse monitor.
    always @(posedge clk) begin
        if (m_we) wr_q.push_back({m_addr, m_wdata});
        if (m_err) err_cnt <= err_cnt + 1;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic arm(input logic [7:0] a);
        @(negedge clk);
        c_start_addr = a;
        c_start = 1'b1;
        @(negedge clk);
        c_start = 1'b0;
    endtask

    // Returns at posedge+1 of the accepting edge (or after the cycle budget expires).
    task automatic send(input logic [1:0] k, input logic [4:0] op, input logic [3:0] arg,
                        input logic [7:0] imm, output bit acc);
        @(negedge clk);
        c_kind = k; c_op = op; c_arg = arg; c_imm = imm; c_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 8 && !acc; i++) begin
            if (m_ready) begin
                @(posedge clk);
                acc = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        #1 c_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        logic [1:0] kind;
        logic [4:0] op;
        logic [3:0] arg;
        logic [7:0] imm;
        int         nw;
        logic [8:0] w0;
        logic [8:0] w1;
        int         ne;
    } vec_t;

    vec_t vt[7];

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit          acc;
        int          n0, e0, hits;
        logic [7:0]  exp_addr;

        vt[0] = '{2'd0, 5'h12, 4'h0, 8'h00, 1, 9'h120, 9'h000, 0};
        vt[1] = '{2'd0, 5'h0A, 4'h3, 8'h00, 1, 9'h0A3, 9'h000, 0};
        vt[2] = '{2'd1, 5'h00, 4'h0, 8'hA5, 2, 9'h005, 9'h01A, 0};
        vt[3] = '{2'd3, 5'h12, 4'h1, 8'h00, 0, 9'h000, 9'h000, 1};
`ifdef INSTR_ENC_CHECK_EN
        vt[4] = '{2'd0, 5'h18, 4'h5, 8'h00, 0, 9'h000, 9'h000, 1};
`else
        vt[4] = '{2'd0, 5'h18, 4'h5, 8'h00, 1, 9'h185, 9'h000, 0};
`endif
        vt[5] = '{2'd1, 5'h00, 4'h0, 8'h00, 2, 9'h000, 9'h010, 0};
        vt[6] = '{2'd2, 5'h00, 4'h0, 8'h00, 1, 9'h1FF, 9'h000, 0};

        sel = 1'b0; c_valid = 1'b0; c_start = 1'b0; c_kind = 2'd0;
        c_op = 5'h00; c_arg = 4'h0; c_imm = 8'h00; c_start_addr = 8'h00;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", m_ready, 1'b0);
        chk("rst_busy", m_busy, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_state", {m_ready, m_we, m_busy, m_done, m_ovf, m_err}, 6'b000000);
        chk("idle_bus", {m_addr, m_wdata}, 17'h00000);

        arm(8'h10);
        chk("armed_busy", m_busy, 1'b1);
        chk("armed_ready", m_ready, 1'b1);

        exp_addr = 8'h10;
        for (int i = 0; i < 7; i++) begin
            n0 = wr_q.size();
            e0 = err_cnt;
            send(vt[i].kind, vt[i].op, vt[i].arg, vt[i].imm, acc);
            if (vt[i].nw == 2) chk($sformatf("v%0d_ready_wrhi", i), m_ready, 1'b0);
            settle();
            chk($sformatf("v%0d_accept", i), acc, 1'b1);
            chk($sformatf("v%0d_nwrites", i), wr_q.size() - n0, vt[i].nw);
            chk($sformatf("v%0d_errs", i), err_cnt - e0, vt[i].ne);
            if (vt[i].nw >= 1 && wr_q.size() > n0) begin
                chk($sformatf("v%0d_w0", i), wr_q[n0], {exp_addr, vt[i].w0});
                exp_addr = exp_addr + 8'd1;
            end
            if (vt[i].nw == 2 && wr_q.size() > n0 + 1) begin
                chk($sformatf("v%0d_w1", i), wr_q[n0+1], {exp_addr, vt[i].w1});
                exp_addr = exp_addr + 8'd1;
            end
        end
        chk("end_status", {m_done, m_busy, m_ovf, m_ready}, 4'b1000);

        n0 = wr_q.size();
        send(2'd0, 5'h12, 4'h2, 8'h00, acc);
        settle();
        chk("done_no_accept", acc, 1'b0);
        chk("done_no_write", wr_q.size() - n0, 0);

        arm(8'h40);
        chk("rearm", {m_done, m_busy, m_ready}, 3'b011);
        n0 = wr_q.size();
        send(2'd0, 5'h12, 4'h0, 8'h00, acc);
        settle();
        chk("rearm_nw", wr_q.size() - n0, 1);
        if (wr_q.size() > n0) chk("rearm_w", wr_q[n0], {8'h40, 9'h120});

        // Reset while the high word of an LDI is pending.
        n0 = wr_q.size();
        send(2'd1, 5'h00, 4'h0, 8'h77, acc);
        chk("ldi2_ready_wrhi", m_ready, 1'b0);
        reset = 1'b1;
        #1;
        chk("midrst_outs", {m_we, m_busy, m_done, m_ovf, m_ready}, 5'b00000);
        chk("midrst_bus", {m_addr, m_wdata}, 17'h00000);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        settle();
        hits = 0;
        for (int j = n0; j < wr_q.size(); j++) if (wr_q[j][8:4] == OP_VALH) hits++;
        chk("midrst_no_hi", hits, 0);
        chk("midrst_idle", {m_busy, m_done}, 2'b00);

        // End-of-memory cases on the 4-word instance.
        @(negedge clk);
        sel = 1'b1;
        arm(8'h03);
        n0 = wr_q.size();
        send(2'd1, 5'h00, 4'h0, 8'h3C, acc);
        settle();
        chk("ovf_nw", wr_q.size() - n0, 1);
        if (wr_q.size() > n0) chk("ovf_w", wr_q[n0], {8'h03, 9'h00C});
        chk("ovf_status", {m_ovf, m_done, m_busy}, 3'b110);

        arm(8'h02);
        chk("ovf_cleared", {m_ovf, m_done}, 2'b00);
        n0 = wr_q.size();
        send(2'd0, 5'h12, 4'h1, 8'h00, acc);
        send(2'd2, 5'h00, 4'h0, 8'h00, acc);
        settle();
        chk("endlast_nw", wr_q.size() - n0, 2);
        if (wr_q.size() > n0 + 1) begin
            chk("endlast_w0", wr_q[n0], {8'h02, 9'h121});
            chk("endlast_w1", wr_q[n0+1], {8'h03, 9'h1FF});
        end
        chk("endlast_status", {m_done, m_ovf}, 2'b10);

        arm(8'h02);
        n0 = wr_q.size();
        send(2'd1, 5'h00, 4'h0, 8'h5A, acc);
        settle();
        chk("hilast_nw", wr_q.size() - n0, 2);
        if (wr_q.size() > n0 + 1) begin
            chk("hilast_w0", wr_q[n0], {8'h02, 9'h00A});
            chk("hilast_w1", wr_q[n0+1], {8'h03, 9'h015});
        end
        chk("hilast_status", {m_ovf, m_done, m_busy}, 3'b110);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
